// File: rtl/axi_burst_chopper_pkg.sv
// Shared types and AX-beat field layout for the burst chopper.
// Offsets are relative to the top of the user field (add UserWidth).
package axi_burst_chopper_pkg;

  localparam int unsigned REGION_OFS = 0;
  localparam int unsigned QOS_OFS    = 4;
  localparam int unsigned PROT_OFS   = 8;
  localparam int unsigned CACHE_OFS  = 11;
  localparam int unsigned LOCK_OFS   = 15;
  localparam int unsigned BURST_OFS  = 16;
  localparam int unsigned SIZE_OFS   = 18;
  localparam int unsigned LEN_OFS    = 21;
  localparam int unsigned ADDR_OFS   = 29;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_e;

  function automatic int unsigned ax_width(
    input int unsigned iw,
    input int unsigned aw,
    input int unsigned uw
  );
    return iw + aw + 29 + uw;
  endfunction

endpackage

// File: rtl/axi_burst_chopper_calc.sv
// Chunk arithmetic: chunk count, current chunk length/last, next address.
// Ports: addr/len/size/burst/rem in; nchunks, beats, chunk_len, last, next_addr out.
module axi_burst_chopper_calc
  import axi_burst_chopper_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned MaxChunkLen = 16
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [7:0]           len,
  input  logic [2:0]           size,
  input  logic [1:0]           burst,
  input  logic [8:0]           rem,
  output logic [8:0]           nchunks,
  output logic [8:0]           beats,
  output logic [7:0]           chunk_len,
  output logic                 last,
  output logic [AddrWidth-1:0] next_addr
);

  localparam logic [8:0] CMax = 9'(MaxChunkLen);

  logic                 is_wrap;
  logic                 is_incr;
  logic                 wrap_split;
  logic [8:0]           total;
  logic [8:0]           c;
  logic [9:0]           ceil_num;
  logic [AddrWidth-1:0] step;
  logic [AddrWidth-1:0] wmask;

  always_comb begin
    is_wrap    = burst == BURST_WRAP;
    is_incr    = burst == BURST_INCR;
    total      = {1'b0, len} + 9'd1;
    // An oversized WRAP is issued beat by beat so each chunk stays in-window
    wrap_split = is_wrap && (total > CMax);
    ceil_num   = {1'b0, total} + 10'(MaxChunkLen - 1);
    nchunks    = wrap_split ? total
                            : 9'(ceil_num / 10'(MaxChunkLen));
    c          = wrap_split ? 9'd1 : CMax;
    beats      = (rem < c) ? rem : c;
    chunk_len  = 8'(beats - 9'd1);
    last       = rem <= c;
    step       = AddrWidth'(1) << size;
    wmask      = (AddrWidth'(total) << size) - AddrWidth'(1);
    next_addr  = addr;
    unique case (1'b1)
      is_incr:
        next_addr = (addr & ~(step - AddrWidth'(1)))
                  + (AddrWidth'(beats) << size);
      is_wrap:
        next_addr = (addr & ~wmask) | ((addr + step) & wmask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_chopper_ax_chan.sv
// AX-channel stage chopping bursts into chunks of <= MaxChunkLen beats.
// Ports: ax_i/valid/ready in, ax_o/last/valid/ready out, meta_o {id,nchunks-1}.
module axi_burst_chopper_ax_chan
  import axi_burst_chopper_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned UserWidth   = 1,
  parameter int unsigned MaxChunkLen = 16,
  localparam int unsigned AxW = ax_width(IdWidth, AddrWidth, UserWidth)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [AxW-1:0]     ax_i,
  input  logic               ax_valid_i,
  output logic               ax_ready_o,
  output logic [AxW-1:0]     ax_o,
  output logic               ax_last_o,
  output logic               ax_valid_o,
  input  logic               ax_ready_i,
  output logic [IdWidth+7:0] meta_o,
  output logic               meta_valid_o,
  input  logic               meta_ready_i
);

  localparam int unsigned LenLsb   = UserWidth + LEN_OFS;
  localparam int unsigned SizeLsb  = UserWidth + SIZE_OFS;
  localparam int unsigned BurstLsb = UserWidth + BURST_OFS;
  localparam int unsigned AddrLsb  = UserWidth + ADDR_OFS;
  localparam int unsigned IdLsb    = AddrLsb + AddrWidth;

  state_e         state_q;
  logic           meta_sent_q;
  logic [AxW-1:0] ax_q;
  logic [8:0]     rem_q;

  logic                 idle;
  logic [AxW-1:0]       ax_src;
  logic [8:0]           total_in;
  logic [8:0]           rem_src;
  logic [8:0]           nchunks;
  logic [8:0]           beats;
  logic [7:0]           chunk_len;
  logic                 last;
  logic [AddrWidth-1:0] next_addr;
  logic                 split_in;
  logic                 meta_ok;
  logic                 accept;

  assign idle     = state_q == IDLE;
  assign total_in = {1'b0, ax_i[LenLsb +: 8]} + 9'd1;
  assign ax_src   = idle ? ax_i : ax_q;
  assign rem_src  = idle ? total_in : rem_q;

  axi_burst_chopper_calc #(
    .AddrWidth   (AddrWidth),
    .MaxChunkLen (MaxChunkLen)
  ) u_calc (
    .addr      (ax_src[AddrLsb +: AddrWidth]),
    .len       (ax_src[LenLsb +: 8]),
    .size      (ax_src[SizeLsb +: 3]),
    .burst     (ax_src[BurstLsb +: 2]),
    .rem       (rem_src),
    .nchunks   (nchunks),
    .beats     (beats),
    .chunk_len (chunk_len),
    .last      (last),
    .next_addr (next_addr)
  );

  assign split_in     = nchunks > 9'd1;
  assign meta_ok      = meta_sent_q | meta_ready_i;
  assign meta_valid_o = ax_valid_i & ~meta_sent_q & idle;
  assign meta_o       = {ax_i[IdLsb +: IdWidth], 8'(nchunks - 9'd1)};
  assign accept       = ax_valid_i & ax_ready_o;

  always_comb begin
    ax_o       = ax_src;
    ax_last_o  = 1'b1;
    ax_valid_o = 1'b0;
    ax_ready_o = 1'b0;
    if (idle) begin
      if (!split_in) begin
        ax_valid_o = ax_valid_i & meta_ok;
        ax_ready_o = ax_valid_i & ax_ready_i & meta_ok;
      end else begin
        ax_ready_o = ax_valid_i & meta_ok;
      end
    end else begin
      ax_o[LenLsb +: 8] = chunk_len;
      ax_valid_o        = 1'b1;
      ax_last_o         = last;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      meta_sent_q <= 1'b0;
      ax_q        <= '0;
      rem_q       <= '0;
    end else begin
      if (accept) begin
        meta_sent_q <= 1'b0;
      end else if (meta_valid_o && meta_ready_i) begin
        meta_sent_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept && split_in) begin
            ax_q    <= ax_i;
            rem_q   <= total_in;
            state_q <= SPLIT;
          end
        end
        SPLIT: begin
          if (ax_ready_i) begin
            rem_q                       <= rem_q - beats;
            ax_q[AddrLsb +: AddrWidth] <= next_addr;
            if (last) state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_chopper_ax_chan.sv
// Directed bench for axi_burst_chopper_ax_chan with MaxChunkLen=4.
// Checks fast path, INCR/FIXED/WRAP splitting, back-pressure and reset.
module tb_axi_burst_chopper_ax_chan;

  localparam int AW  = 32;
  localparam int IW  = 4;
  localparam int UW  = 1;
  localparam int AXW = IW + AW + 29 + UW;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [AXW-1:0] ax_i;
  logic           ax_valid_i;
  logic           ax_ready_o;
  logic [AXW-1:0] ax_o;
  logic           ax_last_o;
  logic           ax_valid_o;
  logic           ax_ready_i;
  logic [IW+7:0]  meta_o;
  logic           meta_valid_o;
  logic           meta_ready_i;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] ea[$];
  logic [7:0]  el[$];

  always #5 clk = ~clk;

  axi_burst_chopper_ax_chan #(
    .AddrWidth   (AW),
    .IdWidth     (IW),
    .UserWidth   (UW),
    .MaxChunkLen (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .ax_i         (ax_i),
    .ax_valid_i   (ax_valid_i),
    .ax_ready_o   (ax_ready_o),
    .ax_o         (ax_o),
    .ax_last_o    (ax_last_o),
    .ax_valid_o   (ax_valid_o),
    .ax_ready_i   (ax_ready_i),
    .meta_o       (meta_o),
    .meta_valid_o (meta_valid_o),
    .meta_ready_i (meta_ready_i)
  );

  function automatic logic [AXW-1:0] mk(
    input logic [3:0]  id,
    input logic [31:0] addr,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    return {id, addr, len, size, burst, 1'b0,
            4'h3, 3'h2, 4'h5, 4'h1, 1'b1};
  endfunction

  function automatic logic [AXW-1:0] strip(input logic [AXW-1:0] v);
    logic [AXW-1:0] r;
    r = v;
    r[29:22] = 8'h00;
    r[61:30] = 32'h0;
    return r;
  endfunction

  task automatic chk(
    input string          tag,
    input logic [AXW-1:0] obs,
    input logic [AXW-1:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_split(
    input logic [AXW-1:0] ax,
    input logic [11:0]    exp_meta
  );
    @(negedge clk);
    ax_i = ax;
    ax_valid_i = 1'b1;
    meta_ready_i = 1'b1;
    ax_ready_i = 1'b1;
    #1;
    chk("acc_meta_valid", meta_valid_o, 1);
    chk("acc_meta", meta_o, exp_meta);
    chk("acc_ready", ax_ready_o, 1);
    chk("acc_no_valid", ax_valid_o, 0);
    @(posedge clk);
    #1;
    ax_valid_i = 1'b0;
    ax_i = '0;
  endtask

  task automatic check_chunks(input logic [AXW-1:0] ax, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("c%0d_valid", i), ax_valid_o, 1);
      chk($sformatf("c%0d_addr", i), ax_o[61:30], ea[i]);
      chk($sformatf("c%0d_len", i), ax_o[29:22], el[i]);
      chk($sformatf("c%0d_last", i), ax_last_o, (i == n - 1));
      chk($sformatf("c%0d_fields", i), strip(ax_o), strip(ax));
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("idle_after", ax_valid_o, 0);
    ea.delete();
    el.delete();
  endtask

  logic [AXW-1:0] ax;
  logic [AXW-1:0] held;

  initial begin
    rst_ni = 1'b0;
    ax_i = '0;
    ax_valid_i = 1'b0;
    ax_ready_i = 1'b0;
    meta_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", ax_valid_o, 0);
    chk("rst_meta_valid", meta_valid_o, 0);
    chk("rst_ready", ax_ready_o, 0);
    rst_ni = 1'b1;

    // Fast path
    @(negedge clk);
    ax = mk(4'h3, 32'h100, 8'd0, 3'd2, 2'b01);
    ax_i = ax;
    ax_valid_i = 1'b1;
    ax_ready_i = 1'b1;
    #1;
    chk("fast_valid", ax_valid_o, 1);
    chk("fast_ready", ax_ready_o, 1);
    chk("fast_last", ax_last_o, 1);
    chk("fast_ax", ax_o, ax);
    chk("fast_meta_valid", meta_valid_o, 1);
    chk("fast_meta", meta_o, {4'h3, 8'd0});
    @(posedge clk);
    #1;
    ax_valid_i = 1'b0;

    // INCR split into 4
    ax = mk(4'h5, 32'h1000, 8'd15, 3'd2, 2'b01);
    accept_split(ax, {4'h5, 8'd3});
    ea = '{32'h1000, 32'h1010, 32'h1020, 32'h1030};
    el = '{8'd3, 8'd3, 8'd3, 8'd3};
    check_chunks(ax, 4);

    // Unaligned INCR
    ax = mk(4'h6, 32'h1002, 8'd7, 3'd2, 2'b01);
    accept_split(ax, {4'h6, 8'd1});
    ea = '{32'h1002, 32'h1010};
    el = '{8'd3, 8'd3};
    check_chunks(ax, 2);

    // FIXED
    ax = mk(4'h8, 32'h2000, 8'd9, 3'd2, 2'b00);
    accept_split(ax, {4'h8, 8'd2});
    ea = '{32'h2000, 32'h2000, 32'h2000};
    el = '{8'd3, 8'd3, 8'd1};
    check_chunks(ax, 3);

    // WRAP split into single beats
    ax = mk(4'h9, 32'h1018, 8'd7, 3'd2, 2'b10);
    accept_split(ax, {4'h9, 8'd7});
    ea = '{32'h1018, 32'h101C, 32'h1000, 32'h1004,
           32'h1008, 32'h100C, 32'h1010, 32'h1014};
    el = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    check_chunks(ax, 8);

    // Meta back-pressure on a fast-path burst
    @(negedge clk);
    ax = mk(4'h7, 32'h300, 8'd2, 3'd2, 2'b01);
    ax_i = ax;
    ax_valid_i = 1'b1;
    meta_ready_i = 1'b0;
    ax_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", ax_valid_o, 0);
      chk("bp_ready", ax_ready_o, 0);
      chk("bp_meta_valid", meta_valid_o, 1);
      @(negedge clk);
    end
    meta_ready_i = 1'b1;
    ax_ready_i = 1'b0;
    #1;
    chk("mh_valid", ax_valid_o, 1);
    chk("mh_ready", ax_ready_o, 0);
    chk("mh_meta", meta_o, {4'h7, 8'd0});
    @(negedge clk);
    meta_ready_i = 1'b0;
    #1;
    chk("nodup_meta_valid", meta_valid_o, 0);
    chk("held_valid", ax_valid_o, 1);
    chk("held_ready", ax_ready_o, 0);
    @(negedge clk);
    ax_ready_i = 1'b1;
    #1;
    chk("rel_ready", ax_ready_o, 1);
    chk("rel_meta_valid", meta_valid_o, 0);
    @(negedge clk);
    ax = mk(4'h2, 32'h400, 8'd0, 3'd2, 2'b01);
    ax_i = ax;
    #1;
    chk("clr_meta_valid", meta_valid_o, 1);
    chk("clr_valid", ax_valid_o, 0);
    meta_ready_i = 1'b1;
    @(posedge clk);
    #1;
    ax_valid_i = 1'b0;

    // ax_ready_i toggling during SPLIT
    ax = mk(4'h4, 32'h3000, 8'd7, 3'd2, 2'b01);
    accept_split(ax, {4'h4, 8'd1});
    @(negedge clk);
    ax_ready_i = 1'b0;
    #1;
    held = ax_o;
    chk("st0_addr", ax_o[61:30], 32'h3000);
    @(negedge clk);
    #1;
    chk("st0_stable", ax_o, held);
    chk("st0_valid", ax_valid_o, 1);
    ax_ready_i = 1'b1;
    @(negedge clk);
    ax_ready_i = 1'b0;
    #1;
    held = ax_o;
    chk("st1_addr", ax_o[61:30], 32'h3010);
    @(negedge clk);
    #1;
    chk("st1_stable", ax_o, held);
    chk("st1_last", ax_last_o, 1);
    ax_ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk("st_idle", ax_valid_o, 0);

    // Reset mid-burst
    ax = mk(4'h2, 32'h5000, 8'd15, 3'd2, 2'b01);
    accept_split(ax, {4'h2, 8'd3});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rb_addr", ax_o[61:30], 32'h5000 + 32'(i * 16));
      @(posedge clk);
    end
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("rb_valid", ax_valid_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    ax = mk(4'h1, 32'h6000, 8'd7, 3'd2, 2'b01);
    accept_split(ax, {4'h1, 8'd1});
    ea = '{32'h6000, 32'h6010};
    el = '{8'd3, 8'd3};
    check_chunks(ax, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
